// File: rtl/div_iter_pkg.sv
// -----------------------------------------------------------------------------
// div_iter_pkg
// Shared definitions for the iterative divider: FSM state encoding and the
// handshake level constants used by the EX-stage divide interface.
// -----------------------------------------------------------------------------
package div_iter_pkg;

  // DivByZero is only reachable when DIV_ZERO_FASTPATH_EN is defined.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Purely combinational two's-complement conditional negation of an operand
// pair. Used on entry to take absolute values of dividend/divisor and on exit
// to restore the signs of remainder/quotient.
// Ports:
//   a_i / neg_a_i -> a_o : a_o = neg_a_i ? -a_i : a_i
//   b_i / neg_b_i -> b_o : b_o = neg_b_i ? -b_i : b_i
// -----------------------------------------------------------------------------
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             neg_b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign a_o = neg_a_i ? (~a_i + ONE) : a_i;
  assign b_o = neg_b_i ? (~b_i + ONE) : b_i;

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Multi-cycle radix-2 restoring divider, responder side of the EX-stage
// divide handshake. EX holds start_i until ready_o, then drops it.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   signed_div_i      1 = DIV (signed), 0 = DIVU; sampled with start
//   opdata1_i         dividend; sampled with start
//   opdata2_i         divisor;  sampled with start
//   start_i           request level, held until ready_o seen
//   annul_i           abort the operation in progress
//   result_o          {remainder, quotient}; zero unless ready_o
//   ready_o           registered result-valid
// Configuration macro:
//   DIV_ZERO_FASTPATH_EN  zero divisor skips the iterations and answers one
//                         cycle after the start sample.
// -----------------------------------------------------------------------------
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  // Before any iteration the partial remainder is below 2^(WIDTH-1), so its
  // top bit never needs storing; only the final remainder uses WIDTH bits.
  logic [WIDTH-2:0]   rem_q, rem_d;
  logic               signed_q, signed_d;
  logic               quot_sign_q, quot_sign_d;
  logic               rem_sign_q, rem_sign_d;
  logic               div_zero_q, div_zero_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0] op1_abs, op2_abs;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   partial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next, quot_next;
  logic [WIDTH-1:0] exit_rem_src;
  logic [WIDTH-1:0] rem_fix, quot_fix;
  logic [2*WIDTH-1:0] final_result;

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_in (
    .a_i     (opdata1_i),
    .neg_a_i (signed_div_i & opdata1_i[WIDTH-1]),
    .b_i     (opdata2_i),
    .neg_b_i (signed_div_i & opdata2_i[WIDTH-1]),
    .a_o     (op1_abs),
    .b_o     (op2_abs)
  );

  // One restoring step: bring down the next dividend bit, trial-subtract,
  // keep the difference when no borrow, shift the quotient bit into dvd.
  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign partial   = {1'b0, shifted} - {1'b0, dvs_q};
  assign borrow    = partial[WIDTH];
  assign rem_next  = borrow ? shifted : partial[WIDTH-1:0];
  assign quot_next = {dvd_q[WIDTH-2:0], ~borrow};

  // With a zero divisor the iterations leave |dividend| in the remainder, and
  // re-applying the dividend sign reproduces the sampled dividend exactly.
  // The fast path has no iterations, so it takes |dividend| straight from dvd.
`ifdef DIV_ZERO_FASTPATH_EN
  assign exit_rem_src = (state_q == DivByZero) ? dvd_q : rem_next;
`else
  assign exit_rem_src = rem_next;
`endif

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_out (
    .a_i     (exit_rem_src),
    .neg_a_i (signed_q & rem_sign_q),
    .b_i     (quot_next),
    .neg_b_i (signed_q & quot_sign_q),
    .a_o     (rem_fix),
    .b_o     (quot_fix)
  );

  assign final_result = {rem_fix, (div_zero_q ? {WIDTH{1'b1}} : quot_fix)};

  // Next-state, datapath and output logic of the divide FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    signed_d    = signed_q;
    quot_sign_d = quot_sign_q;
    rem_sign_d  = rem_sign_q;
    div_zero_d  = div_zero_q;
    result_d    = result_q;
    ready_d     = ready_q;

    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          dvd_d       = op1_abs;
          dvs_d       = op2_abs;
          rem_d       = '0;
          cnt_d       = '0;
          signed_d    = signed_div_i;
          quot_sign_d = opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
          rem_sign_d  = opdata1_i[WIDTH-1];
          div_zero_d  = (opdata2_i == '0);
`ifdef DIV_ZERO_FASTPATH_EN
          state_d     = (opdata2_i == '0) ? DivByZero : DivOn;
`else
          state_d     = DivOn;
`endif
        end
      end

      DivByZero: begin
`ifdef DIV_ZERO_FASTPATH_EN
        if (annul_i || start_i == DivStop) begin
          state_d = DivFree;
        end else begin
          result_d = final_result;
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
`else
        state_d = DivFree;
`endif
      end

      DivOn: begin
        // Abort wins over a completion landing on the same edge.
        if (annul_i || start_i == DivStop) begin
          state_d = DivFree;
        end else begin
          dvd_d = quot_next;
          rem_d = rem_next[WIDTH-2:0];
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
            result_d = final_result;
            ready_d  = DivResultReady;
            state_d  = DivEnd;
          end
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end
      end

      default: begin
        state_d = DivFree;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DivFree;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      signed_q    <= 1'b0;
      quot_sign_q <= 1'b0;
      rem_sign_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      result_q    <= '0;
      ready_q     <= DivResultNotReady;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      signed_q    <= signed_d;
      quot_sign_q <= quot_sign_d;
      rem_sign_q  <= rem_sign_d;
      div_zero_q  <= div_zero_d;
      result_q    <= result_d;
      ready_q     <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Self-checking bench for div_iter: a table of known divide results, a set of
// hand-written handshake corner cases, and random operations checked against
// a plain-arithmetic reference model. Honours DIV_ZERO_FASTPATH_EN for the
// expected divide-by-zero latency.
// -----------------------------------------------------------------------------
module tb_div_iter;

  localparam int WIDTH = 32;
`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = WIDTH;
`endif

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  div_iter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic; SV '/' and '%' truncate toward
  // zero with the remainder taking the dividend's sign.
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request and hold start until ready or the cycle budget expires.
  // Operand inputs are scrambled after the sampling edge to prove they were
  // captured. lat is the number of edges after the sampling edge, -1 on timeout.
  task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                               input logic [31:0] b, output logic [63:0] res,
                               output int lat, output logic busy_bad);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    annul      = 1'b0;
    busy_bad   = 1'b0;
    lat        = -1;
    res        = '0;
    waitCycles(1);
    signed_div = ~sgn;
    opdata1    = $urandom;
    opdata2    = $urandom;
    for (int n = 1; n <= 100; n++) begin
      waitCycles(1);
      if (ready) begin
        lat = n;
        res = result;
        break;
      end
      if (result !== '0) busy_bad = 1'b1;
    end
  endtask

  // Full transaction: result, latency, DONE hold (annul ignored), release.
  task automatic runOp(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp);
    logic [63:0] res;
    int          lat;
    logic        busy_bad;
    int          exp_lat;
    exp_lat = (b == 32'd0) ? ZERO_LAT : WIDTH;
    applyStimulus(sgn, a, b, res, lat, busy_bad);
    checkOutput({name, " result"}, res, exp);
    checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, " busy_zero"}, {63'd0, busy_bad}, 64'd0);
    if (lat > 0) begin
      annul = 1'b1;
      waitCycles(1);
      annul = 1'b0;
      checkOutput({name, " hold_ready"}, {63'd0, ready}, 64'd1);
      checkOutput({name, " hold_result"}, result, exp);
    end
    start = 1'b0;
    waitCycles(1);
    checkOutput({name, " clear_ready"}, {63'd0, ready}, 64'd0);
    checkOutput({name, " clear_result"}, result, 64'd0);
  endtask

  // Watch ready_o for n cycles; returns 1 if it ever rose.
  task automatic watchReady(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      waitCycles(1);
      if (ready) seen = 1'b1;
    end
  endtask

  initial begin
    logic        seen;
    logic        sgn;
    logic [31:0] a, b;
    logic [63:0] res;
    int          lat;
    logic        busy_bad;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD}};
    vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}};
    vecs[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000,  32'd0}};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFF_FFFF}};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB,  32'hFFFF_FFFF}};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  {32'd1,          32'd1}};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         {32'd3,          32'd0}};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE,  32'd14}};
    vecs[10] = '{1'b1, 32'h8000_0000,  32'd1,          {32'd0,          32'h8000_0000}};
    vecs[11] = '{1'b1, 32'd0,          32'hFFFF_FFFD,  {32'd0,          32'd0}};

    rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    start = 1'b0; annul = 1'b0;
    waitCycles(2);
    checkOutput("reset ready", {63'd0, ready}, 64'd0);
    checkOutput("reset result", result, 64'd0);
    rst = 1'b0;
    waitCycles(1);

    for (int i = 0; i < 12; i++)
      runOp($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Annul pulse on iteration 10, EX drops start with it.
    $display("[TB] annul mid-calculation");
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    waitCycles(10);
    annul = 1'b1;
    waitCycles(1);
    annul = 1'b0; start = 1'b0;
    watchReady(40, seen);
    checkOutput("annul no_ready", {63'd0, seen}, 64'd0);
    runOp("post_annul 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Start dropped mid-calculation aborts the operation.
    $display("[TB] start dropped mid-calculation");
    opdata1 = 32'd500; opdata2 = 32'd9; start = 1'b1;
    waitCycles(6);
    start = 1'b0;
    watchReady(40, seen);
    checkOutput("drop no_ready", {63'd0, seen}, 64'd0);

    // Annul on the completing edge beats completion.
    $display("[TB] annul on final iteration");
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    waitCycles(1 + WIDTH - 1);
    annul = 1'b1;
    waitCycles(1);
    checkOutput("annul_final ready", {63'd0, ready}, 64'd0);
    annul = 1'b0; start = 1'b0;
    watchReady(3, seen);
    checkOutput("annul_final later", {63'd0, seen}, 64'd0);

    // Start with annul held in IDLE is never accepted.
    $display("[TB] start blocked by annul");
    opdata1 = 32'd50; opdata2 = 32'd5; start = 1'b1; annul = 1'b1;
    watchReady(40, seen);
    checkOutput("idle_annul no_ready", {63'd0, seen}, 64'd0);
    start = 1'b0; annul = 1'b0;
    waitCycles(1);

    // Asynchronous reset between edges mid-calculation.
    $display("[TB] reset mid-calculation");
    opdata1 = 32'd77; opdata2 = 32'd7; start = 1'b1;
    waitCycles(11);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_calc ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_calc result", result, 64'd0);
    start = 1'b0;
    waitCycles(2);
    rst = 1'b0;
    watchReady(3, seen);
    checkOutput("rst_calc no_ready", {63'd0, seen}, 64'd0);
    runOp("post_rst -9/4", 1'b1, 32'hFFFF_FFF7, 32'd4, {32'hFFFF_FFFF, 32'hFFFF_FFFE});

    // Asynchronous reset while a result is being presented clears it at once.
    $display("[TB] reset in done");
    applyStimulus(1'b0, 32'd100, 32'd7, res, lat, busy_bad);
    checkOutput("rst_done pre", res, {32'd2, 32'd14});
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_done ready", {63'd0, ready}, 64'd0);
    checkOutput("rst_done result", result, 64'd0);
    start = 1'b0;
    waitCycles(1);
    rst = 1'b0;
    waitCycles(1);

    // Random operations against the reference model.
    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       begin b = $urandom; a = 32'($urandom_range(0, 1000)); end
        default: b = $urandom;
      endcase
      runOp($sformatf("rand%0d", i), sgn, a, b, refDiv(sgn, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
